// File: rtl/selector_channel.sv
// Selector channel: drives one device through an initial selection, byte
// transfers (read or write) and ending status, using the classic
// tag-in/tag-out bus handshake. Every output is a flop, loaded from the
// decode of the state being entered.
module selector_channel #(
    parameter int ADDR_DELAY  = 4,
    parameter int TIMEOUT     = 1023,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             bus_in,
    output logic [7:0]             bus_out,
    input  logic                   operational_in,
    input  logic                   select_in,
    input  logic                   address_in,
    input  logic                   status_in,
    input  logic                   service_in,
    input  logic                   request_in,
    output logic                   operational_out,
    output logic                   hold_out,
    output logic                   select_out,
    output logic                   address_out,
    output logic                   command_out,
    output logic                   service_out,
    output logic                   suppress_out,
    input  logic [7:0]             address,
    input  logic [7:0]             command,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic                   start_strobe,
    output logic                   active,
    output logic [7:0]             status,
    output logic                   status_strobe,
    output logic [COUNT_WIDTH-1:0] res_count,
    input  logic [7:0]             tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [7:0]             rx_data,
    output logic                   rx_valid,
    output logic [2:0]             result,
    output logic                   done_strobe
);

    typedef enum logic [3:0] {
        IDLE, ADDR_OUT, SEL_OUT, ADDR_IN, CMD_OUT, INIT_STATUS,
        INIT_ACCEPT, SELECTED, DATA, STOP, ENDING, BUSY_ACCEPT
    } state_t;

    localparam int TMAX = (TIMEOUT > ADDR_DELAY) ? TIMEOUT : ADDR_DELAY;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] A_LAST = TW'(ADDR_DELAY - 1);

    localparam logic [2:0] R_OK       = 3'd0;
    localparam logic [2:0] R_NOT_OPER = 3'd1;
    localparam logic [2:0] R_BUSY     = 3'd2;
    localparam logic [2:0] R_UNIT     = 3'd3;
    localparam logic [2:0] R_TIMEOUT  = 3'd4;
    localparam logic [2:0] R_ADDR     = 3'd5;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [7:0]             addr_q, addr_d, cmd_q, cmd_d, data_q, data_d;
    logic [COUNT_WIDTH-1:0] res_count_q, res_count_d;
    logic [7:0]             status_q, status_d, rx_data_q, rx_data_d;
    logic [7:0]             bus_out_q, bus_out_d;
    logic [2:0]             result_q, result_d;
    logic                   status_strobe_q, status_strobe_d;
    logic                   rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
    logic                   done_strobe_q, done_strobe_d, active_q, active_d;
    logic                   oper_q, hold_q, hold_d, sel_q, sel_d;
    logic                   addr_out_q, addr_out_d, cmd_out_q, cmd_out_d;
    logic                   svc_out_q, svc_out_d;
    logic                   timed;

    // request_in is part of the bus but this channel never polls devices.
    logic unused_request;
    assign unused_request = request_in;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cmd_d           = cmd_q;
        data_d          = data_q;
        res_count_d     = res_count_q;
        status_d        = status_q;
        rx_data_d       = rx_data_q;
        result_d        = result_q;
        status_strobe_d = 1'b0;
        rx_valid_d      = 1'b0;
        tx_ready_d      = 1'b0;
        timed           = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_strobe && !select_in && !status_in && !operational_in) begin
                    addr_d      = address;
                    cmd_d       = command;
                    res_count_d = count;
                    state_d     = ADDR_OUT;
                end
            end
            ADDR_OUT: begin
                if (timer_q == A_LAST) state_d = SEL_OUT;
            end
            SEL_OUT: begin
                timed = 1'b1;
                if (operational_in) begin
                    state_d = ADDR_IN;
                end else if (status_in) begin
                    status_d        = bus_in;
                    status_strobe_d = 1'b1;
                    result_d        = R_BUSY;
                    state_d         = BUSY_ACCEPT;
                end else if (select_in) begin
                    result_d = R_NOT_OPER;
                    state_d  = IDLE;
                end
            end
            ADDR_IN: begin
                timed = 1'b1;
                if (address_in) begin
                    if (bus_in == addr_q) begin
                        state_d = CMD_OUT;
                    end else begin
                        result_d = R_ADDR;
                        state_d  = IDLE;
                    end
                end
            end
            CMD_OUT: begin
                timed = 1'b1;
                if (!address_in) state_d = INIT_STATUS;
            end
            INIT_STATUS: begin
                timed = 1'b1;
                if (status_in) begin
                    status_d        = bus_in;
                    status_strobe_d = 1'b1;
                    state_d         = INIT_ACCEPT;
                end
            end
            INIT_ACCEPT: begin
                if (!status_in) begin
                    if (status_q == 8'h00 && cmd_q != 8'h00) begin
                        state_d = SELECTED;
                    end else begin
                        result_d = (cmd_q == 8'h00) ? R_OK : R_UNIT;
                        state_d  = IDLE;
                    end
                end
            end
            BUSY_ACCEPT: begin
                if (!status_in) state_d = IDLE;
            end
            SELECTED: begin
                timed = 1'b1;
                if (service_in) begin
                    if (res_count_q == '0) begin
                        state_d = STOP;
                    end else if (cmd_q[0]) begin
                        // Capture the byte on the accepting edge; the source holds
                        // it until tx_ready is seen on the next clock.
                        if (tx_valid) begin
                            data_d     = tx_data;
                            tx_ready_d = 1'b1;
                            state_d    = DATA;
                        end
                    end else begin
                        rx_data_d  = bus_in;
                        rx_valid_d = 1'b1;
                        state_d    = DATA;
                    end
                end else if (status_in) begin
                    status_d        = bus_in;
                    status_strobe_d = 1'b1;
                    state_d         = ENDING;
                end
            end
            DATA: begin
                if (!service_in) begin
                    if (res_count_q != '0) res_count_d = res_count_q - COUNT_WIDTH'(1);
                    state_d = SELECTED;
                end
            end
            STOP: begin
                timed = 1'b1;
                if (!service_in) state_d = SELECTED;
            end
            ENDING: begin
                timed = 1'b1;
                if (!status_in) begin
                    if (status_q[2]) begin
                        result_d = (status_q == 8'h0C) ? R_OK : R_UNIT;
                        state_d  = IDLE;
                    end else begin
                        state_d = SELECTED;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A device that stays silent for TIMEOUT clocks in a waiting state is abandoned.
        if (timed && state_d == state_q && timer_q == T_LAST) begin
            result_d = R_TIMEOUT;
            state_d  = IDLE;
        end

        if (state_d != state_q)  timer_d = '0;
        else if (timer_q != '1)  timer_d = timer_q + TW'(1);
        else                     timer_d = timer_q;

        addr_out_d    = (state_d == ADDR_OUT) || (state_d == SEL_OUT);
        hold_d        = (state_d != IDLE) && (state_d != ADDR_OUT);
        sel_d         = hold_d;
        cmd_out_d     = (state_d == CMD_OUT) || (state_d == STOP);
        svc_out_d     = (state_d == INIT_ACCEPT) || (state_d == BUSY_ACCEPT) ||
                        (state_d == DATA) || (state_d == ENDING);
        active_d      = (state_d != IDLE);
        done_strobe_d = (state_q != IDLE) && (state_d == IDLE);

        case (state_d)
            ADDR_OUT, SEL_OUT: bus_out_d = addr_d;
            CMD_OUT:           bus_out_d = cmd_d;
            DATA:              bus_out_d = cmd_d[0] ? data_d : 8'h00;
            default:           bus_out_d = 8'h00;
        endcase
    end

    // State and output registers; reset drops every tag at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            timer_q         <= '0;
            addr_q          <= '0;
            cmd_q           <= '0;
            data_q          <= '0;
            res_count_q     <= '0;
            status_q        <= '0;
            rx_data_q       <= '0;
            result_q        <= '0;
            bus_out_q       <= '0;
            status_strobe_q <= 1'b0;
            rx_valid_q      <= 1'b0;
            tx_ready_q      <= 1'b0;
            done_strobe_q   <= 1'b0;
            active_q        <= 1'b0;
            oper_q          <= 1'b0;
            hold_q          <= 1'b0;
            sel_q           <= 1'b0;
            addr_out_q      <= 1'b0;
            cmd_out_q       <= 1'b0;
            svc_out_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            addr_q          <= addr_d;
            cmd_q           <= cmd_d;
            data_q          <= data_d;
            res_count_q     <= res_count_d;
            status_q        <= status_d;
            rx_data_q       <= rx_data_d;
            result_q        <= result_d;
            bus_out_q       <= bus_out_d;
            status_strobe_q <= status_strobe_d;
            rx_valid_q      <= rx_valid_d;
            tx_ready_q      <= tx_ready_d;
            done_strobe_q   <= done_strobe_d;
            active_q        <= active_d;
            oper_q          <= 1'b1;
            hold_q          <= hold_d;
            sel_q           <= sel_d;
            addr_out_q      <= addr_out_d;
            cmd_out_q       <= cmd_out_d;
            svc_out_q       <= svc_out_d;
        end
    end

    assign bus_out         = bus_out_q;
    assign operational_out = oper_q;
    assign hold_out        = hold_q;
    assign select_out      = sel_q;
    assign address_out     = addr_out_q;
    assign command_out     = cmd_out_q;
    assign service_out     = svc_out_q;
    assign suppress_out    = 1'b0;
    assign active          = active_q;
    assign status          = status_q;
    assign status_strobe   = status_strobe_q;
    assign res_count       = res_count_q;
    assign tx_ready        = tx_ready_q;
    assign rx_data         = rx_data_q;
    assign rx_valid        = rx_valid_q;
    assign result          = result_q;
    assign done_strobe     = done_strobe_q;

endmodule

// File: tb/tb_selector_channel.sv
// Directed bench for selector_channel: a scripted device answers the tag
// handshake and every observation is compared against hand-derived values.
module tb_selector_channel;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    bus_in = '0, bus_out;
    logic          operational_in = 0, select_in = 0, address_in = 0;
    logic          status_in = 0, service_in = 0, request_in = 0;
    logic          operational_out, hold_out, select_out, address_out;
    logic          command_out, service_out, suppress_out;
    logic [7:0]    address = '0, command = '0;
    logic [CW-1:0] count = '0;
    logic          start_strobe = 0;
    logic          active;
    logic [7:0]    status;
    logic          status_strobe;
    logic [CW-1:0] res_count;
    logic [7:0]    tx_data = '0;
    logic          tx_valid = 0, tx_ready;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [2:0]    result;
    logic          done_strobe;

    selector_channel #(.ADDR_DELAY(4), .TIMEOUT(16), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .bus_out(bus_out),
        .operational_in(operational_in), .select_in(select_in), .address_in(address_in),
        .status_in(status_in), .service_in(service_in), .request_in(request_in),
        .operational_out(operational_out), .hold_out(hold_out), .select_out(select_out),
        .address_out(address_out), .command_out(command_out), .service_out(service_out),
        .suppress_out(suppress_out), .address(address), .command(command), .count(count),
        .start_strobe(start_strobe), .active(active), .status(status),
        .status_strobe(status_strobe), .res_count(res_count), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .result(result), .done_strobe(done_strobe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, stat_cnt = 0, cmd_cnt = 0, rx_n = 0;
    logic [7:0] rx_buf [8];

    // Pulse monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (done_strobe)   done_cnt <= done_cnt + 1;
        if (status_strobe) stat_cnt <= stat_cnt + 1;
        if (command_out)   cmd_cnt  <= cmd_cnt + 1;
        if (rx_valid) begin
            rx_buf[rx_n & 7] <= rx_data;
            rx_n             <= rx_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    localparam int W_ACT = 0, W_SEL = 1, W_CMD = 2, W_SVC = 3, W_TXR = 4;

    function automatic logic sigv(input int w);
        case (w)
            W_ACT:   return active;
            W_SEL:   return select_out;
            W_CMD:   return command_out;
            W_SVC:   return service_out;
            W_TXR:   return tx_ready;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait for a DUT output level; an expired wait shows up as a failed check.
    task automatic wait_for(input int w, input logic val, input string tag);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sigv(w) == val) break;
        end
        chk(tag, sigv(w), val);
    endtask

    function automatic logic [6:0] tags();
        return {operational_out, hold_out, select_out, address_out,
                command_out, service_out, suppress_out};
    endfunction

    task automatic start_op(input logic [7:0] a, input logic [7:0] c, input logic [CW-1:0] n);
        @(negedge clk);
        address = a; command = c; count = n; start_strobe = 1'b1;
        @(posedge clk);
        #1 start_strobe = 1'b0;
    endtask

    // Device side of selection, command and a zero initial status.
    task automatic prologue(input logic [7:0] a, input logic [7:0] c);
        wait_for(W_SEL, 1'b1, "sel_up");
        operational_in = 1'b1; address_in = 1'b1; bus_in = a;
        wait_for(W_CMD, 1'b1, "cmd_up");
        chk("cmd_byte", bus_out, c);
        address_in = 1'b0; status_in = 1'b1; bus_in = 8'h00;
        wait_for(W_SVC, 1'b1, "init_svc");
        status_in = 1'b0;
        wait_for(W_SVC, 1'b0, "init_svc_dn");
    endtask

    task automatic xfer_rd(input logic [7:0] b);
        bus_in = b; service_in = 1'b1;
        wait_for(W_SVC, 1'b1, "rd_svc");
        service_in = 1'b0;
        wait_for(W_SVC, 1'b0, "rd_svc_dn");
    endtask

    task automatic ending(input logic [7:0] st);
        bus_in = st; status_in = 1'b1;
        wait_for(W_SVC, 1'b1, "end_svc");
        status_in = 1'b0;
        wait_for(W_ACT, 1'b0, "end_idle");
        @(negedge clk);
        operational_in = 1'b0; bus_in = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, s0, c0, held, n;

        // Reset state
        #1;
        chk("rst_tags", tags(), 7'h00);
        chk("rst_bus", bus_out, 8'h00);
        chk("rst_active", active, 1'b0);
        chk("rst_result", result, 3'd0);
        chk("rst_rescnt", res_count, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("oper_after_rst", operational_out, 1'b1);

        // Start refused while the bus is busy
        select_in = 1'b1;
        start_op(8'h05, 8'h02, 16'd3);
        @(negedge clk);
        chk("start_refused", active, 1'b0);
        select_in = 1'b0;

        // Read 3 bytes, ending status 0x0C
        d0 = done_cnt; rx_n = 0;
        start_op(8'h05, 8'h02, 16'd3);
        prologue(8'h05, 8'h02);
        xfer_rd(8'hA1); xfer_rd(8'hA2); xfer_rd(8'hA3);
        ending(8'h0C);
        chk("rd_rx_n", rx_n, 3);
        chk("rd_b0", rx_buf[0], 8'hA1);
        chk("rd_b1", rx_buf[1], 8'hA2);
        chk("rd_b2", rx_buf[2], 8'hA3);
        chk("rd_rescnt", res_count, 16'd0);
        chk("rd_result", result, 3'd0);
        chk("rd_status", status, 8'h0C);
        chk("rd_done", done_cnt - d0, 1);

        // Write 2 bytes, first tx_valid late by 5 clocks
        start_op(8'h05, 8'h01, 16'd2);
        prologue(8'h05, 8'h01);
        service_in = 1'b1; held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (service_out || tx_ready) held++;
        end
        chk("wr_held_off", held, 0);
        tx_valid = 1'b1; tx_data = 8'hB1;
        wait_for(W_TXR, 1'b1, "wr_rdy0");
        chk("wr_svc0", service_out, 1'b1);
        chk("wr_bus0", bus_out, 8'hB1);
        @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'h00; service_in = 1'b0;
        wait_for(W_SVC, 1'b0, "wr_svc0_dn");
        chk("wr_rescnt1", res_count, 16'd1);
        tx_valid = 1'b1; tx_data = 8'hB2; service_in = 1'b1;
        wait_for(W_TXR, 1'b1, "wr_rdy1");
        chk("wr_bus1", bus_out, 8'hB2);
        @(posedge clk); #1 tx_valid = 1'b0; tx_data = 8'h00; service_in = 1'b0;
        wait_for(W_SVC, 1'b0, "wr_svc1_dn");
        chk("wr_rescnt0", res_count, 16'd0);
        ending(8'h0C);
        chk("wr_result", result, 3'd0);

        // Count exhausted: service_in answered with command_out (stop), count stays 0
        start_op(8'h05, 8'h02, 16'd1);
        prologue(8'h05, 8'h02);
        xfer_rd(8'h55);
        service_in = 1'b1;
        wait_for(W_CMD, 1'b1, "stop_cmd");
        chk("stop_svc", service_out, 1'b0);
        service_in = 1'b0;
        wait_for(W_CMD, 1'b0, "stop_cmd_dn");
        chk("stop_rescnt", res_count, 16'd0);
        ending(8'h04);
        chk("de_only_result", result, 3'd3);

        // Short busy on select
        s0 = stat_cnt; c0 = cmd_cnt;
        start_op(8'h05, 8'h02, 16'd1);
        wait_for(W_SEL, 1'b1, "busy_sel");
        status_in = 1'b1; bus_in = 8'h10;
        wait_for(W_SVC, 1'b1, "busy_svc");
        status_in = 1'b0; bus_in = 8'h00;
        wait_for(W_ACT, 1'b0, "busy_idle");
        @(negedge clk);
        chk("busy_status", status, 8'h10);
        chk("busy_strobes", stat_cnt - s0, 1);
        chk("busy_no_cmd", cmd_cnt - c0, 0);
        chk("busy_result", result, 3'd2);

        // Address mismatch
        start_op(8'h05, 8'h02, 16'd1);
        wait_for(W_SEL, 1'b1, "mm_sel");
        operational_in = 1'b1; address_in = 1'b1; bus_in = 8'h07;
        wait_for(W_ACT, 1'b0, "mm_idle");
        chk("mm_result", result, 3'd5);
        chk("mm_hold_sel", {hold_out, select_out}, 2'b00);
        @(negedge clk);
        operational_in = 1'b0; address_in = 1'b0; bus_in = 8'h00;

        // Silent device: address alone for 4 clocks, select for 16, then abort
        start_op(8'h05, 8'h02, 16'd1);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (select_out) break;
            if (address_out) n++;
        end
        chk("addr_delay", n, 4);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (!select_out) break;
            n++;
            @(negedge clk);
        end
        chk("timeout_clocks", n, 16);
        chk("timeout_result", result, 3'd4);
        chk("timeout_tags", tags(), 7'b1000000);
        chk("timeout_active", active, 1'b0);

        // Reset while in DATA
        start_op(8'h05, 8'h02, 16'd2);
        prologue(8'h05, 8'h02);
        bus_in = 8'h66; service_in = 1'b1;
        wait_for(W_SVC, 1'b1, "rst_data_svc");
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_tags", tags(), 7'h00);
        chk("rst_mid_active", active, 1'b0);
        @(negedge clk);
        service_in = 1'b0; operational_in = 1'b0; bus_in = 8'h00;
        reset_n = 1'b1;
        #1 chk("rst_rel_oper0", operational_out, 1'b0);
        @(posedge clk); #1;
        chk("rst_rel_oper1", operational_out, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
